// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit for the 8-bit datapath: fetch/decode/exec/mem/wb
// sequencing, memory ready-stretching with bus timeout, and retired-instruction count.
//
//   state  | meaning
//   FETCH  | read instruction byte, wait for mem_ready, bump PC
//   DECODE | dispatch on opcode; NOP/JMP/HALT/illegal retire here
//   EXEC   | ALU operation or BEQ compare/branch
//   MEM    | LD read or ST write, held until mem_ready
//   WB     | register file write (ALU result or load data)
//   HALT   | idle with all enables low until reset
module main_control_fsm #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       instr,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic             reg_write,
  output logic [1:0]       ALUOp,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t           r_state;
  logic [3:0]       r_opcode;
  logic [7:0]       r_wait;
  logic [CNT_W-1:0] r_retired;
  logic             r_illegal;
  logic             r_bus_err;

  logic w_mem_state;
  logic w_timeout;
  logic w_is_alu;
  logic w_opc_illegal;
  logic w_dec_retire;
  logic w_retire;
  logic w_unused_instr;

  assign w_unused_instr = ^instr[3:0];

  assign w_mem_state   = (r_state == S_FETCH) || (r_state == S_MEM);
  // The MAX_WAIT-th cycle without ready is the last one tolerated; ready on it still succeeds.
  assign w_timeout     = w_mem_state && !mem_ready && (r_wait == WAIT_LAST);
  assign w_is_alu      = (r_opcode == OP_ADD) || (r_opcode == OP_SUB) ||
                         (r_opcode == OP_AND) || (r_opcode == OP_OR);
  assign w_opc_illegal = (r_opcode >= 4'h9) && (r_opcode <= 4'hE);
  assign w_dec_retire  = !(w_is_alu || (r_opcode == OP_LD) || (r_opcode == OP_ST) ||
                           (r_opcode == OP_BEQ));

  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_DECODE: w_retire = w_dec_retire;
      S_EXEC:   w_retire = (r_opcode == OP_BEQ);
      S_MEM:    w_retire = mem_ready && (r_opcode == OP_ST);
      S_WB:     w_retire = 1'b1;
      default:  w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_opcode  <= OP_NOP;
      r_wait    <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_mem_state && !mem_ready && !w_timeout) r_wait <= r_wait + 8'd1;
      else                                         r_wait <= '0;

      if (w_retire) r_retired <= r_retired + CNT_W'(1);

      if (w_timeout) begin
        r_bus_err <= 1'b1;
        r_state   <= S_HALT;
      end else begin
        case (r_state)
          S_FETCH: if (mem_ready) begin
            r_opcode <= instr[7:4];
            r_state  <= S_DECODE;
          end
          S_DECODE: begin
            if (w_opc_illegal) r_illegal <= 1'b1;
            if (w_is_alu || (r_opcode == OP_BEQ))             r_state <= S_EXEC;
            else if ((r_opcode == OP_LD) || (r_opcode == OP_ST)) r_state <= S_MEM;
            else if (r_opcode == OP_HALT)                     r_state <= S_HALT;
            else                                              r_state <= S_FETCH;
          end
          S_EXEC:  r_state <= w_is_alu ? S_WB : S_FETCH;
          S_MEM: if (mem_ready) r_state <= (r_opcode == OP_LD) ? S_WB : S_FETCH;
          S_WB:    r_state <= S_FETCH;
          S_HALT:  r_state <= S_HALT;
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

  // Enables are decoded from state and gated by rst_n so nothing is asserted during reset.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    ALUOp      = 2'b00;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_read = 1'b1;
          pc_write = mem_ready;
          ir_write = mem_ready;
        end
        S_DECODE: if (r_opcode == OP_JMP) begin
          pc_write = 1'b1;
          pc_src   = 2'b01;
        end
        S_EXEC: begin
          if (r_opcode == OP_BEQ) begin
            ALUOp    = 2'b01;
            pc_src   = 2'b10;
            pc_write = zero;
          end else begin
            ALUOp = r_opcode[1:0] - 2'd1;
          end
        end
        S_MEM: begin
          alu_src = 1'b1;
          if (r_opcode == OP_LD) mem_read  = 1'b1;
          else                   mem_write = 1'b1;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (r_opcode == OP_LD);
        end
        default: ;
      endcase
    end
  end

  assign halted  = (r_state == S_HALT);
  assign illegal = r_illegal;
  assign bus_err = r_bus_err;
  assign retired = r_retired;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: stimulus queues hand-computed per-cycle
// output vectors, a negedge monitor pops and compares them against the DUT.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] instr;
  logic       mem_ready;
  logic       zero;
  logic       pc_write, ir_write, mem_read, mem_write, mem_to_reg, alu_src, reg_write;
  logic       halted, illegal, bus_err;
  logic [1:0] pc_src, ALUOp;
  logic [7:0] retired;

  main_control_fsm #(.MAX_WAIT(15), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .reg_write(reg_write), .ALUOp(ALUOp), .halted(halted), .illegal(illegal),
    .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] v;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        e_ill    = 1'b0;
  logic        e_be     = 1'b0;
  logic [7:0]  e_ret    = 8'd0;
  exp_t        m_e;
  logic [21:0] m_act;

  // Vector layout: pcw, pc_src, irw, mem_read, mem_write, mem_to_reg, alu_src,
  // reg_write, ALUOp, halted, illegal, bus_err, retired.
  function automatic logic [21:0] ex(input logic pcw, input logic [1:0] pcs,
                                     input logic irw, input logic mr, input logic mw,
                                     input logic m2r, input logic as_, input logic rw,
                                     input logic [1:0] op, input logic h);
    return {pcw, pcs, irw, mr, mw, m2r, as_, rw, op, h, e_ill, e_be, e_ret};
  endfunction

  function automatic logic [21:0] fv(input logic r);
    return ex(r, 2'b00, r, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endfunction

  function automatic logic [21:0] idle();
    return ex(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e   = q.pop_front();
      m_act = {pc_write, pc_src, ir_write, mem_read, mem_write, mem_to_reg, alu_src,
               reg_write, ALUOp, halted, illegal, bus_err, retired};
      n_checks++;
      if (m_act === m_e.v) n_pass++;
      else $display("FAIL %s: got %b expected %b", m_e.name, m_act, m_e.v);
    end
  end

  task automatic cyc(input logic [7:0] i, input logic r, input logic z,
                     input logic [21:0] v, input string nm);
    instr     = i;
    mem_ready = r;
    zero      = z;
    q.push_back('{v: v, name: nm});
    @(posedge clk);
    #1;
  endtask

  task automatic alu_instr(input logic [3:0] op, input logic [1:0] aluop_exp);
    cyc({op, 4'h6}, 1'b1, 1'b0, fv(1'b1), "alu_fetch");
    cyc({op, 4'h6}, 1'b1, 1'b0, idle(), "alu_decode");
    cyc({op, 4'h6}, 1'b1, 1'b0, ex(0, 2'b00, 0, 0, 0, 0, 0, 0, aluop_exp, 0), "alu_exec");
    cyc({op, 4'h6}, 1'b1, 1'b0, ex(0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0), "alu_wb");
    e_ret++;
  endtask

  task automatic beq_instr(input logic z);
    cyc(8'h80, 1'b1, ~z, fv(1'b1), "beq_fetch");
    cyc(8'h80, 1'b1, ~z, idle(), "beq_decode");
    cyc(8'h80, 1'b0, z, ex(z, 2'b10, 0, 0, 0, 0, 0, 0, 2'b01, 0), "beq_exec");
    e_ret++;
  endtask

  task automatic nop_instr(input logic [7:0] i, input string nm);
    cyc(i, 1'b1, 1'b0, fv(1'b1), nm);
    cyc(i, 1'b1, 1'b0, idle(), nm);
    e_ret++;
  endtask

  initial begin
    rst_n = 1'b0; instr = 8'h00; mem_ready = 1'b0; zero = 1'b0;
    @(posedge clk);
    #1;
    cyc(8'h00, 1'b1, 1'b1, idle(), "reset_outputs");
    rst_n = 1'b1;

    alu_instr(4'h1, 2'b00);
    alu_instr(4'h2, 2'b01);
    alu_instr(4'h3, 2'b10);
    alu_instr(4'h4, 2'b11);

    // LD with three stalled MEM cycles
    cyc(8'h54, 1'b1, 1'b0, fv(1'b1), "ld_fetch");
    cyc(8'h54, 1'b0, 1'b0, idle(), "ld_decode");
    repeat (3) cyc(8'h54, 1'b0, 1'b0, ex(0, 2'b00, 0, 1, 0, 0, 1, 0, 2'b00, 0), "ld_mem_stall");
    cyc(8'h54, 1'b1, 1'b0, ex(0, 2'b00, 0, 1, 0, 0, 1, 0, 2'b00, 0), "ld_mem_done");
    cyc(8'h54, 1'b0, 1'b0, ex(0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 0), "ld_wb");
    e_ret++;

    cyc(8'h60, 1'b1, 1'b0, fv(1'b1), "st_fetch");
    cyc(8'h60, 1'b1, 1'b0, idle(), "st_decode");
    cyc(8'h60, 1'b1, 1'b0, ex(0, 2'b00, 0, 0, 1, 0, 1, 0, 2'b00, 0), "st_mem");
    e_ret++;

    beq_instr(1'b1);
    beq_instr(1'b0);

    cyc(8'h70, 1'b1, 1'b0, fv(1'b1), "jmp_fetch");
    cyc(8'h70, 1'b1, 1'b0, ex(1, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0), "jmp_decode");
    e_ret++;

    nop_instr(8'h00, "nop");
    nop_instr(8'hA0, "illegal");
    e_ill = 1'b1;

    // Ready arrives on exactly the 15th FETCH cycle: success, no bus error
    repeat (14) cyc(8'h00, 1'b0, 1'b0, fv(1'b0), "fetch_wait");
    cyc(8'h00, 1'b1, 1'b0, fv(1'b1), "fetch_wait_last_ok");
    cyc(8'h00, 1'b0, 1'b0, idle(), "fetch_wait_decode");
    e_ret++;

    // Run the retired counter across its wrap point
    repeat (260) nop_instr(8'h00, "wrap_nop");
    cyc(8'h00, 1'b0, 1'b0, fv(1'b0), "after_wrap");

    // Asynchronous reset in the middle of an ST memory access
    cyc(8'h00, 1'b1, 1'b0, fv(1'b1), "pre_st");
    cyc(8'h00, 1'b1, 1'b0, idle(), "pre_st_decode");
    e_ret++;
    cyc(8'h60, 1'b1, 1'b0, fv(1'b1), "st2_fetch");
    cyc(8'h60, 1'b0, 1'b0, idle(), "st2_decode");
    cyc(8'h60, 1'b0, 1'b0, ex(0, 2'b00, 0, 0, 1, 0, 1, 0, 2'b00, 0), "st2_mem_hold");
    e_ill = 1'b0; e_be = 1'b0; e_ret = 8'd0;
    q.push_back('{v: idle(), name: "async_reset_mid_mem"});
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    cyc(8'h60, 1'b1, 1'b0, idle(), "held_in_reset");
    rst_n = 1'b1;

    // Fetch timeout: 15 cycles without ready
    repeat (15) cyc(8'h00, 1'b0, 1'b0, fv(1'b0), "timeout_fetch");
    e_be = 1'b1;
    repeat (3) cyc(8'h00, 1'b1, 1'b1, ex(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1), "timeout_halt");

    rst_n = 1'b0;
    e_be = 1'b0;
    cyc(8'hF0, 1'b0, 1'b0, idle(), "reset2");
    rst_n = 1'b1;

    nop_instr(8'hF0, "halt_instr");
    repeat (100) cyc(8'hF0, 1'b1, 1'b1, ex(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1), "halt_hold");

    @(posedge clk);
    #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
